deinterleaver: RTL and testbench

DEINTERLEAVER -- requirements
Module: deinterleaver

---
 rtl/wimax_pkg.sv | 27 ++
 rtl/deinterleaver_addr_gen.sv | 37 +++
 rtl/deinterleaver.sv | 103 ++++++++++
 tb/tb_deinterleaver.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/wimax_pkg.sv
// Shared constants and the write-side address mapping for the block deinterleaver.
package wimax_pkg;

  localparam int NCBPS_DEF = 192;
  localparam int NCPC_DEF  = 2;
  localparam int S_DEF     = NCPC_DEF / 2;
  localparam int D_DEF     = 16;

  // Index width for one block, and the width needed to hold d*(Ncbps-1).
  localparam int IDX_W  = $clog2(NCBPS_DEF);
  localparam int PROD_W = $clog2(D_DEF * (NCBPS_DEF - 1) + 1);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  // Original-order address of the j-th received bit. Evaluated in 32-bit int,
  // which comfortably covers d*(Ncbps-1) for any practical block size.
  function automatic int calc_kj(input int j, input int ncbps, input int s_p, input int d_p);
    int m;
    m = s_p * (j / s_p) + ((j + (d_p * j) / ncbps) % s_p);
    return d_p * m - (ncbps - 1) * ((d_p * m) / ncbps);
  endfunction

endpackage

// File: rtl/deinterleaver_addr_gen.sv
// Write-side counter: tracks the position j within the block and maps it to
// the original-order address kj where the received bit belongs.
module deinterleaver_addr_gen
  import wimax_pkg::*;
#(
  parameter int Ncbps = NCBPS_DEF,
  parameter int s     = S_DEF,
  parameter int d     = D_DEF,
  localparam int IW   = $clog2(Ncbps)
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          adv_i,
  output logic [IW-1:0] wr_addr_o,
  output logic          eob_o
);

  logic [IW-1:0] j_q, j_d;

  assign eob_o     = (j_q == IW'(Ncbps - 1));
  assign wr_addr_o = IW'(calc_kj(int'(j_q), Ncbps, s, d));

  // Advance on each accepted bit; wrap to 0 after the last bit of a block.
  always_comb begin
    j_d = j_q;
    if (adv_i) begin
      j_d = eob_o ? '0 : j_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (resetN) j_q <= '0;
    else        j_q <= j_d;
  end

endmodule

// File: rtl/deinterleaver.sv
// Ping-pong block deinterleaver: received bits are scattered into one bank at
// their original-order address while the other, completed bank is streamed
// out sequentially to the decoder.
module deinterleaver
  import wimax_pkg::*;
#(
  parameter int Ncbps = NCBPS_DEF,
  parameter int Ncpc  = NCPC_DEF,
  parameter int s     = Ncpc / 2,
  parameter int d     = D_DEF,
  localparam int IW   = $clog2(Ncbps)
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          valid_in,
  input  logic          data_in,
  output logic          ready_in,
  input  logic          ready_out,
  output logic          data_out,
  output logic [IW-1:0] data_out_index,
  output logic          valid_out
);

  logic [Ncbps-1:0] bank_q [2];
  bank_state_e      bank_st_q [2];
  bank_state_e      bank_st_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]    rd_cnt_q, rd_cnt_d;
  logic [IW-1:0]    wr_addr;
  logic             wr_eob;
  logic             wr_fire, rd_fire, rd_last;

  // Handshakes are forced low while reset is held so nothing moves.
  assign ready_in       = ~resetN & (bank_st_q[wr_ptr_q] != BANK_FULL);
  assign valid_out      = ~resetN & (bank_st_q[rd_ptr_q] == BANK_FULL);
  assign data_out       = valid_out & bank_q[rd_ptr_q][rd_cnt_q];
  assign data_out_index = resetN ? '0 : rd_cnt_q;

  assign wr_fire = valid_in & ready_in;
  assign rd_fire = valid_out & ready_out;
  assign rd_last = (rd_cnt_q == IW'(Ncbps - 1));

  deinterleaver_addr_gen #(
    .Ncbps (Ncbps),
    .s     (s),
    .d     (d)
  ) u_addr_gen (
    .clk       (clk),
    .resetN    (resetN),
    .adv_i     (wr_fire),
    .wr_addr_o (wr_addr),
    .eob_o     (wr_eob)
  );

  // Bank lifecycle and pointer/counter next state. A write and a read never
  // target the same bank: writes need a non-full bank, reads a full one.
  always_comb begin
    bank_st_d = bank_st_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_cnt_d  = rd_cnt_q;
    if (wr_fire) begin
      if (wr_eob) begin
        bank_st_d[wr_ptr_q] = BANK_FULL;
        wr_ptr_d            = ~wr_ptr_q;
      end else begin
        bank_st_d[wr_ptr_q] = BANK_FILLING;
      end
    end
    if (rd_fire) begin
      if (rd_last) begin
        bank_st_d[rd_ptr_q] = BANK_EMPTY;
        rd_cnt_d            = '0;
        rd_ptr_d            = ~rd_ptr_q;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (resetN) begin
      bank_st_q[0] <= BANK_EMPTY;
      bank_st_q[1] <= BANK_EMPTY;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      rd_cnt_q     <= '0;
    end else begin
      bank_st_q <= bank_st_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  // Bank storage; contents are not cleared by reset, the state flags guard them.
  always_ff @(posedge clk) begin
    if (wr_fire) bank_q[wr_ptr_q][wr_addr] <= data_in;
  end

endmodule

// File: tb/tb_deinterleaver.sv
// Directed bench for the ping-pong deinterleaver.
module tb_deinterleaver;

  logic       clk = 1'b0;
  logic       resetN;
  logic       valid_in;
  logic       data_in;
  logic       ready_in;
  logic       ready_out;
  logic       data_out;
  logic [7:0] data_out_index;
  logic       valid_out;

  logic [191:0] in_vec  = 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E;
  logic [191:0] out_vec = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;

  int n_checks = 0;
  int n_fail   = 0;
  int first_vo, last_vo, vo_cnt;

  always #5 clk = ~clk;

  deinterleaver dut (
    .clk            (clk),
    .resetN         (resetN),
    .valid_in       (valid_in),
    .data_in        (data_in),
    .ready_in       (ready_in),
    .ready_out      (ready_out),
    .data_out       (data_out),
    .data_out_index (data_out_index),
    .valid_out      (valid_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle-by-cycle streaming: drive after the edge, check and count transfers
  // at the falling edge. Called with the time just after a rising edge.
  task automatic stream(input int n_in, input int n_out, input bit gaps,
                        input int rout_hold, input int probe_cyc, input int max_cyc);
    int in_cnt, out_cnt, cyc, jj, kk;
    in_cnt = 0; out_cnt = 0; cyc = 0;
    first_vo = -1; last_vo = -1; vo_cnt = 0;
    while ((in_cnt < n_in || out_cnt < n_out) && cyc < max_cyc) begin
      jj        = in_cnt % 192;
      valid_in  = (in_cnt < n_in) && (gaps ? ($urandom_range(0, 1) == 1) : 1'b1);
      data_in   = in_vec[191 - jj];
      ready_out = (cyc >= rout_hold) && (gaps ? ($urandom_range(0, 1) == 1) : 1'b1);
      @(negedge clk);
      if (cyc == probe_cyc) begin
        chk("stall_accepted", in_cnt, 384);
        chk("stall_ready_in", {31'd0, ready_in}, 0);
      end
      if (valid_in && ready_in) begin
        case (jj)
          0:   chk("addr_j0",   {24'd0, dut.u_addr_gen.wr_addr_o}, 0);
          1:   chk("addr_j1",   {24'd0, dut.u_addr_gen.wr_addr_o}, 16);
          12:  chk("addr_j12",  {24'd0, dut.u_addr_gen.wr_addr_o}, 1);
          191: chk("addr_j191", {24'd0, dut.u_addr_gen.wr_addr_o}, 191);
          default: ;
        endcase
        in_cnt++;
      end
      if (valid_out) begin
        kk = out_cnt % 192;
        if (first_vo < 0) first_vo = cyc;
        last_vo = cyc;
        vo_cnt++;
        chk("out_index", {24'd0, data_out_index}, kk);
        chk("out_data",  {31'd0, data_out}, {31'd0, out_vec[191 - kk]});
        if (ready_out) out_cnt++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("in_count",  in_cnt,  n_in);
    chk("out_count", out_cnt, n_out);
    valid_in  = 1'b0;
    ready_out = 1'b0;
  endtask

  initial begin
    resetN    = 1'b1;
    valid_in  = 1'b0;
    data_in   = 1'b0;
    ready_out = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_in",  {31'd0, ready_in}, 0);
    chk("rst_valid_out", {31'd0, valid_out}, 0);
    chk("rst_data_out",  {31'd0, data_out}, 0);
    chk("rst_index",     {24'd0, data_out_index}, 0);
    @(posedge clk); #1;
    resetN = 1'b0;
    @(negedge clk);
    chk("post_rst_ready_in",  {31'd0, ready_in}, 1);
    chk("post_rst_valid_out", {31'd0, valid_out}, 0);
    @(posedge clk); #1;

    // Single block, no gaps.
    stream(192, 192, 1'b0, 0, -1, 1000);

    // Two back-to-back blocks: output valid from cycle 192 (0-based), continuous.
    stream(384, 384, 1'b0, 0, -1, 2000);
    chk("b2b_first_valid", first_vo, 192);
    chk("b2b_valid_cycles", vo_cnt, 384);
    chk("b2b_contiguous", last_vo - first_vo + 1, 384);

    // Output stalled for 400 cycles: input must stop at 384 accepted bits.
    stream(576, 576, 1'b0, 400, 395, 3000);

    // Random 50% gaps on both sides.
    stream(192, 192, 1'b1, 0, -1, 5000);

    // Reset in mid-block at input bit 100.
    stream(100, 0, 1'b0, 0, -1, 500);
    resetN = 1'b1;
    valid_in = 1'b1;
    ready_out = 1'b1;
    @(negedge clk);
    chk("midrst_ready_in",  {31'd0, ready_in}, 0);
    chk("midrst_valid_out", {31'd0, valid_out}, 0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ready_in2",  {31'd0, ready_in}, 0);
    chk("midrst_valid_out2", {31'd0, valid_out}, 0);
    chk("midrst_index",      {24'd0, data_out_index}, 0);
    @(posedge clk); #1;
    resetN = 1'b0;
    valid_in = 1'b0;
    ready_out = 1'b0;
    @(negedge clk);
    chk("after_rst_ready_in",  {31'd0, ready_in}, 1);
    chk("after_rst_valid_out", {31'd0, valid_out}, 0);
    @(posedge clk); #1;
    stream(192, 192, 1'b0, 0, -1, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
